// File: rtl/imm_lag_smoother.sv
// rtl/imm_lag_smoother.sv - IMM mode-combining stage with a fixed-lag constant-velocity smoother
//
// Mixes the per-model state estimates of a 3-model IMM filter (CV, CT+, CT-)
// by their mode probabilities, keeps the last LAG+1 combined states in a
// circular history, and emits a smoothed estimate for the sample LAG inputs
// back. All arithmetic is signed Q16.16.
//
// Ports
//   clk           rising-edge clock
//   rst_n         synchronous active-low reset
//   fwd_valid     one-cycle strobe, fwd_xf/fwd_mu valid this cycle
//   fwd_xf        model m, state s at [(m*4+s)*32 +: 32], s = x, y, vx, vy
//   fwd_mu        mode probability of model m at [m*32 +: 32]
//   dt            sample period
//   enable        smoother output enable
//   filt_valid    combined-estimate strobe (2 cycles after fwd_valid)
//   x_filt        combined state {vy, vx, y, x}
//   smooth_valid  smoothed-estimate strobe (3 cycles after fwd_valid)
//   x_smooth      smoothed state {vy, vx, y, x}
//   dominant_mode argmax of mu, lowest index wins ties
//   fill_count    stored samples, saturating at LAG+1
module imm_lag_smoother #(
   parameter int LAG = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         fwd_valid,
   input  logic [383:0] fwd_xf,
   input  logic [95:0]  fwd_mu,
   input  logic [31:0]  dt,
   input  logic         enable,
   output logic         filt_valid,
   output logic [127:0] x_filt,
   output logic         smooth_valid,
   output logic [127:0] x_smooth,
   output logic [1:0]   dominant_mode,
   output logic [3:0]   fill_count
);

   localparam int             DEPTH = LAG + 1;
   localparam int             PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [PW-1:0]  LAST  = PW'(LAG);
   localparam logic [4:0]     FULL  = 5'(DEPTH);

   function automatic logic signed [31:0] mul(input logic signed [31:0] a,
                                              input logic signed [31:0] b);
      return 32'(($signed(64'(a)) * $signed(64'(b))) >>> 16);
   endfunction

   // Stage 1: products and argmax
   logic                v1_q;
   logic signed [31:0]  prod_q [3][4];
   logic [1:0]          dm1_q;
   logic [1:0]          dm1_d;

   // Stage 2: combined state
   logic                filt_valid_q;
   logic [127:0]        x_filt_q;
   logic [127:0]        x_filt_d;
   logic [1:0]          dm_q;

   // History and smoother
   logic [127:0]        hist_q [DEPTH];
   logic [PW-1:0]       wr_ptr_q;
   logic [PW-1:0]       nxt_ptr;
   logic [4:0]          fill_q;
   logic                smooth_valid_q;
   logic [127:0]        x_smooth_q;
   logic [127:0]        x_smooth_d;
   logic                win_full;

   logic [127:0]        xo;
   logic [31:0]         t_w;
   logic signed [31:0]  pk, vk, po, vo, pb, ps, vs;

   always_comb begin
      logic signed [31:0] best;
      dm1_d = 2'd0;
      best  = $signed(fwd_mu[31:0]);
      // strict greater-than keeps the lower index on ties
      if ($signed(fwd_mu[63:32]) > best) begin
         dm1_d = 2'd1;
         best  = $signed(fwd_mu[63:32]);
      end
      if ($signed(fwd_mu[95:64]) > best) begin
         dm1_d = 2'd2;
      end
   end

   always_comb begin
      x_filt_d = '0;
      for (int s = 0; s < 4; s++) begin
         x_filt_d[s*32 +: 32] = prod_q[0][s] + prod_q[1][s] + prod_q[2][s];
      end
   end

   // The slot after the write pointer holds the sample written LAG writes ago.
   assign nxt_ptr  = (wr_ptr_q == LAST) ? '0 : wr_ptr_q + 1'b1;
   // This write completes a window of LAG+1 samples, so xo is valid history.
   assign win_full = (fill_q >= 5'(LAG));

   always_comb begin
      xo         = hist_q[nxt_ptr];
      t_w        = dt * 32'(LAG);
      x_smooth_d = '0;
      pk = '0; vk = '0; po = '0; vo = '0; pb = '0; ps = '0; vs = '0;
      for (int a = 0; a < 2; a++) begin
         pk = $signed(x_filt_q[a*32 +: 32]);
         vk = $signed(x_filt_q[(a+2)*32 +: 32]);
         po = $signed(xo[a*32 +: 32]);
         vo = $signed(xo[(a+2)*32 +: 32]);
         pb = pk - mul(t_w, vk);
         ps = po + pb;
         vs = vo + vk;
         x_smooth_d[a*32 +: 32]     = ps >>> 1;
         x_smooth_d[(a+2)*32 +: 32] = vs >>> 1;
      end
   end

   always_ff @(posedge clk) begin
      if (fwd_valid) begin
         for (int m = 0; m < 3; m++) begin
            for (int s = 0; s < 4; s++) begin
               prod_q[m][s] <= mul(fwd_mu[m*32 +: 32], fwd_xf[(m*4+s)*32 +: 32]);
            end
         end
         dm1_q <= dm1_d;
      end
   end

   always_ff @(posedge clk) begin
      if (filt_valid_q) begin
         hist_q[wr_ptr_q] <= x_filt_q;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         v1_q           <= 1'b0;
         filt_valid_q   <= 1'b0;
         x_filt_q       <= '0;
         dm_q           <= 2'd0;
         wr_ptr_q       <= '0;
         fill_q         <= '0;
         smooth_valid_q <= 1'b0;
         x_smooth_q     <= '0;
      end else begin
         v1_q           <= fwd_valid;
         filt_valid_q   <= v1_q;
         smooth_valid_q <= 1'b0;
         if (v1_q) begin
            x_filt_q <= x_filt_d;
            dm_q     <= dm1_q;
         end
         if (filt_valid_q) begin
            wr_ptr_q <= nxt_ptr;
            if (fill_q != FULL) begin
               fill_q <= fill_q + 5'd1;
            end
            if (win_full && enable) begin
               smooth_valid_q <= 1'b1;
               x_smooth_q     <= x_smooth_d;
            end
         end
      end
   end

   assign filt_valid    = filt_valid_q;
   assign x_filt        = x_filt_q;
   assign smooth_valid  = smooth_valid_q;
   assign x_smooth      = x_smooth_q;
   assign dominant_mode = dm_q;
   // LAG=15 saturates at 16, which the 4-bit port reports as 15
   assign fill_count    = (fill_q > 5'd15) ? 4'd15 : fill_q[3:0];

endmodule

// File: tb/tb_imm_lag_smoother.sv
// tb/tb_imm_lag_smoother.sv - scoreboard testbench for imm_lag_smoother
module tb_imm_lag_smoother;

   localparam logic [31:0] ONE  = 32'h0001_0000;
   localparam logic [31:0] HALF = 32'h0000_8000;
   localparam logic [31:0] TWO  = 32'h0002_0000;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         fwd_valid;
   logic [383:0] fwd_xf;
   logic [95:0]  fwd_mu;
   logic [31:0]  dt;
   logic         enable;
   logic         filt_valid;
   logic [127:0] x_filt;
   logic         smooth_valid;
   logic [127:0] x_smooth;
   logic [1:0]   dominant_mode;
   logic [3:0]   fill_count;

   always #5 clk = ~clk;

   imm_lag_smoother #(.LAG(4)) dut (
      .clk(clk), .rst_n(rst_n), .fwd_valid(fwd_valid), .fwd_xf(fwd_xf),
      .fwd_mu(fwd_mu), .dt(dt), .enable(enable), .filt_valid(filt_valid),
      .x_filt(x_filt), .smooth_valid(smooth_valid), .x_smooth(x_smooth),
      .dominant_mode(dominant_mode), .fill_count(fill_count)
   );

   typedef struct { logic [127:0] x; logic [1:0] dm; int cyc; } fexp_t;
   typedef struct { logic [127:0] x; int cyc; } sexp_t;

   fexp_t fq[$];
   sexp_t sq[$];
   fexp_t fe;
   sexp_t se;
   int    cyc = 0;
   int    n_vec = 0;
   int    n_err = 0;

   logic [31:0] sm_x [4] = '{32'h0, 32'h8000, 32'h1_0000, 32'h1_8000};

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [127:0] st(input logic [31:0] x, input logic [31:0] y,
                                       input logic [31:0] vx, input logic [31:0] vy);
      return {vy, vx, y, x};
   endfunction

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (filt_valid) begin
         if (fq.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL unexpected_filt_valid at cycle %0d", cyc);
         end else begin
            fe = fq.pop_front();
            chk("x_filt", x_filt, fe.x);
            chk("dominant_mode", 128'(dominant_mode), 128'(fe.dm));
            chk("filt_latency", 128'(cyc), 128'(fe.cyc));
         end
      end
      if (smooth_valid) begin
         if (sq.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL unexpected_smooth_valid at cycle %0d", cyc);
         end else begin
            se = sq.pop_front();
            chk("x_smooth", x_smooth, se.x);
            chk("smooth_latency", 128'(cyc), 128'(se.cyc));
         end
      end
   end

   task automatic send(input logic [127:0] m0, input logic [127:0] m1, input logic [127:0] m2,
                       input logic [95:0] mu, input logic [127:0] ef, input logic [1:0] edm,
                       input bit es, input logic [127:0] esx);
      fexp_t f;
      sexp_t s;
      fwd_xf    = {m2, m1, m0};
      fwd_mu    = mu;
      fwd_valid = 1'b1;
      @(posedge clk); #1;
      fwd_valid = 1'b0;
      f.x = ef; f.dm = edm; f.cyc = cyc + 1;
      fq.push_back(f);
      if (es) begin
         s.x = esx; s.cyc = cyc + 2;
         sq.push_back(s);
      end
   endtask

   // Pure CV sample k of the smoothing ramp: x = 0.5k, vx = 2.0
   task automatic ramp(input int k, input bit es, input logic [31:0] esx);
      send(st(32'(k) * HALF, 32'h0, TWO, 32'h0), st(32'h1234_5678, 32'h7, 32'h9, 32'hFFFF_0000),
           st(32'h0, 32'h0, 32'h0, 32'h0), {32'h0, 32'h0, ONE},
           st(32'(k) * HALF, 32'h0, TWO, 32'h0), 2'd0, es, st(esx, 32'h0, TWO, 32'h0));
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n     = 1'b0;
      fwd_valid = 1'b1;
      fwd_xf    = {12{32'h0003_0000}};
      fwd_mu    = {3{ONE}};
      repeat (2) @(posedge clk);
      #1;
      fwd_valid = 1'b0;
      chk("rst_filt_valid", 128'(filt_valid), 128'(0));
      chk("rst_smooth_valid", 128'(smooth_valid), 128'(0));
      chk("rst_x_filt", x_filt, 128'(0));
      chk("rst_x_smooth", x_smooth, 128'(0));
      chk("rst_dominant_mode", 128'(dominant_mode), 128'(0));
      chk("rst_fill_count", 128'(fill_count), 128'(0));
      rst_n = 1'b1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog_timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; fwd_valid = 1'b0; fwd_xf = '0; fwd_mu = '0;
      dt = 32'h0000_4000; enable = 1'b1;
      do_reset();
      idle(3);
      chk("idle_after_reset_fill", 128'(fill_count), 128'(0));

      // pure CV
      send(st(32'h000A_0000, 32'h0014_0000, 32'h0001_0000, 32'h0002_0000),
           st(32'h1111_0000, 32'h2222_0000, 32'h3333_0000, 32'h4444_0000),
           st(32'h5555_0000, 32'h6666_0000, 32'h7777_0000, 32'h0123_0000),
           {32'h0, 32'h0, ONE},
           st(32'h000A_0000, 32'h0014_0000, 32'h0001_0000, 32'h0002_0000), 2'd0, 1'b0, '0);
      // mixing and tie
      send(st(32'h000A_0000, 32'h0004_0000, 32'h0, 32'h0),
           st(32'h0014_0000, 32'hFFFE_0000, 32'h0, 32'h0),
           st(32'h0099_0000, 32'h0088_0000, 32'h0, 32'h0),
           {32'h0, HALF, HALF},
           st(32'h000F_0000, 32'h0001_0000, 32'h0, 32'h0), 2'd0, 1'b0, '0);
      // argmax at model 2
      send(st(ONE, 32'h0, 32'h0, 32'h0), st(32'h0, 32'h0, 32'h0, 32'h0),
           st(TWO, 32'h0, 32'h0, 32'h0),
           {32'h0000_8000, 32'h0000_4CCC, 32'h0000_3333},
           st(32'h0001_3333, 32'h0, 32'h0, 32'h0), 2'd2, 1'b0, '0);
      idle(4);
      chk("fill_after_3", 128'(fill_count), 128'(3));

      // smoothing ramp
      do_reset();
      for (int k = 0; k < 8; k++) begin
         if (k >= 4) ramp(k, 1'b1, sm_x[k-4]);
         else        ramp(k, 1'b0, 32'h0);
      end
      idle(4);
      chk("fill_saturated", 128'(fill_count), 128'(5));
      chk("x_smooth_last", x_smooth, st(32'h0001_8000, 32'h0, TWO, 32'h0));

      // enable gating on a full buffer
      enable = 1'b0;
      for (int k = 0; k < 6; k++) begin
         ramp(k, 1'b0, 32'h0);
         chk("gated_fill", 128'(fill_count), 128'(5));
      end
      idle(4);
      chk("gated_x_smooth_hold", x_smooth, st(32'h0001_8000, 32'h0, TWO, 32'h0));
      enable = 1'b1;
      ramp(6, 1'b1, 32'h0001_0000);
      ramp(7, 1'b1, 32'h0001_8000);
      idle(4);

      // reset mid-stream
      fwd_xf = {12{32'h0005_0000}}; fwd_mu = {3{ONE}}; fwd_valid = 1'b1;
      @(posedge clk); #1;
      fwd_valid = 1'b0;
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      idle(4);
      chk("midrst_fill", 128'(fill_count), 128'(0));
      chk("midrst_x_filt", x_filt, 128'(0));
      for (int k = 0; k < 5; k++) begin
         ramp(k, k == 4, 32'h0);
      end
      idle(4);

      // back-to-back from empty
      do_reset();
      for (int k = 0; k < 6; k++) begin
         if (k >= 4) ramp(k, 1'b1, sm_x[k-4]);
         else        ramp(k, 1'b0, 32'h0);
      end
      idle(5);

      chk("filt_queue_drained", 128'(fq.size()), 128'(0));
      chk("smooth_queue_drained", 128'(sq.size()), 128'(0));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
